// File: rtl/spi_cmd_engine_if.sv
// Single-byte memory bus between spi_cmd_engine (master) and the register/memory fabric (slave).
interface spi_cmd_engine_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/spi_cmd_engine.sv
// SPI command parser turning framed read/write commands into single-byte bus transactions.
// Optional SPI_CMD_ERRCNT_EN adds a saturating error counter readable with CMD 0x03.
module spi_cmd_engine (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ssel_n,
    input  logic               data_ready,
    input  logic [7:0]         data_recv,
    output logic [7:0]         data_send,
    spi_cmd_engine_if.master   bus,
    output logic               busy,
    output logic               err
);

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, LEN, DUMMY, WDATA, RDATA, DISCARD
    } state_t;

    state_t      state;
    logic [15:0] addr;
    logic [8:0]  len_cnt;
    logic [8:0]  fetch_cnt;
    logic [7:0]  next_buf;
    logic        next_valid;
    logic        rd_keep;
    logic        is_write;
    logic        ssel_q;

    logic        active;
    logic        bus_free;
    logic        rd_ack;
    logic        consume;
    logic        buf_full_next;
    logic        issue_rd;
    logic        wr_issue;
    logic        overrun;
    logic        underrun;
    logic [7:0]  send_byte;

    // At most one of {valid next_buf, read in flight} exists, so a read is only issued once both are gone.
    assign active        = !ssel_n;
    assign bus_free      = !bus.mem_req || bus.mem_ack;
    assign rd_ack        = bus.mem_req && bus.mem_ack && !bus.mem_we && rd_keep;
    assign consume       = active && data_ready &&
                           (state == DUMMY || (state == RDATA && len_cnt != 9'd1));
    assign buf_full_next = (next_valid || rd_ack) && !consume;
    assign issue_rd      = active && (state == DUMMY || state == RDATA) &&
                           fetch_cnt != 9'd0 && bus_free && !buf_full_next;
    assign wr_issue      = active && data_ready && state == WDATA && bus_free;
    assign overrun       = active && data_ready && state == WDATA && !bus_free;
    assign underrun      = consume && !next_valid && !rd_ack;
    assign send_byte     = next_valid ? next_buf : (rd_ack ? bus.mem_rdata : 8'hEE);
    assign busy          = (state != IDLE);

`ifdef SPI_CMD_ERRCNT_EN
    logic [7:0] err_cnt;
    logic       cnt_inc;
    logic       cnt_clr;
    logic       unknown_cmd;

    assign unknown_cmd = active && data_ready && state == IDLE &&
                         data_recv != 8'h01 && data_recv != 8'h02 && data_recv != 8'h03;
    assign cnt_clr     = active && data_ready && state == IDLE && data_recv == 8'h03;
    assign cnt_inc     = overrun || underrun || unknown_cmd ||
                         (ssel_n && (state == DUMMY || state == WDATA || state == RDATA));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if (cnt_clr) begin
            err_cnt <= 8'h00;
        end else if (cnt_inc && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= 16'h0000;
            len_cnt       <= 9'd0;
            fetch_cnt     <= 9'd0;
            next_buf      <= 8'h00;
            next_valid    <= 1'b0;
            rd_keep       <= 1'b0;
            is_write      <= 1'b0;
            ssel_q        <= 1'b1;
            data_send     <= 8'h00;
            err           <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 16'h0000;
            bus.mem_wdata <= 8'h00;
        end else begin
            ssel_q <= ssel_n;
            if (ssel_q && !ssel_n)
                err <= 1'b0;
            if (overrun || underrun)
                err <= 1'b1;

            if (bus.mem_ack)
                bus.mem_req <= 1'b0;
            if (rd_ack) begin
                next_buf   <= bus.mem_rdata;
                next_valid <= 1'b1;
            end
            if (consume)
                next_valid <= 1'b0;

            if (issue_rd) begin
                bus.mem_req  <= 1'b1;
                bus.mem_we   <= 1'b0;
                bus.mem_addr <= addr;
                addr         <= addr + 16'd1;
                fetch_cnt    <= fetch_cnt - 9'd1;
                rd_keep      <= 1'b1;
            end
            if (wr_issue) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= addr;
                bus.mem_wdata <= data_recv;
                addr          <= addr + 16'd1;
            end

            // Deselect aborts the frame; any in-flight request finishes but its read data is dropped.
            if (ssel_n) begin
                state      <= IDLE;
                data_send  <= 8'h00;
                rd_keep    <= 1'b0;
                next_valid <= 1'b0;
            end else if (data_ready) begin
                data_send <= 8'h00;
                case (state)
                    IDLE: begin
                        case (data_recv)
                            8'h01: begin is_write <= 1'b1; state <= ADDR_HI; end
                            8'h02: begin is_write <= 1'b0; state <= ADDR_HI; end
`ifdef SPI_CMD_ERRCNT_EN
                            8'h03: begin data_send <= err_cnt; state <= DISCARD; end
`endif
                            default: state <= DISCARD;
                        endcase
                    end
                    ADDR_HI: begin addr[15:8] <= data_recv; state <= ADDR_LO; end
                    ADDR_LO: begin addr[7:0]  <= data_recv; state <= LEN; end
                    LEN: begin
                        len_cnt   <= {data_recv == 8'h00, data_recv};
                        fetch_cnt <= {data_recv == 8'h00, data_recv};
                        state     <= is_write ? WDATA : DUMMY;
                    end
                    DUMMY: begin
                        data_send <= send_byte;
                        state     <= RDATA;
                    end
                    WDATA: begin
                        len_cnt <= len_cnt - 9'd1;
                        if (len_cnt == 9'd1)
                            state <= DISCARD;
                    end
                    RDATA: begin
                        len_cnt <= len_cnt - 9'd1;
                        if (len_cnt == 9'd1)
                            state <= DISCARD;
                        else
                            data_send <= send_byte;
                    end
                    DISCARD: state <= DISCARD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_engine.sv
// Directed self-checking bench for spi_cmd_engine with a latency-programmable memory model.
module tb_spi_cmd_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ssel_n = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_recv = 8'h00;
    logic [7:0] data_send;
    logic       busy;
    logic       err;

    spi_cmd_engine_if bus();

    spi_cmd_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ssel_n     (ssel_n),
        .data_ready (data_ready),
        .data_recv  (data_recv),
        .data_send  (data_send),
        .bus        (bus),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Memory model: acks after 'lat' waiting cycles, logs every completed transaction.
    logic [7:0]  mem [0:65535];
    logic [15:0] log_addr [0:63];
    logic [7:0]  log_data [0:63];
    logic        log_we   [0:63];
    int          log_n = 0;
    int          req_cycles = 0;
    int          wait_cnt = 0;
    int          lat = 2;

    always @(posedge clk) begin
        bus.mem_ack <= 1'b0;
        if (bus.mem_req)
            req_cycles <= req_cycles + 1;
        if (!bus.mem_req || bus.mem_ack) begin
            wait_cnt <= 0;
        end else if (wait_cnt >= lat) begin
            bus.mem_ack   <= 1'b1;
            bus.mem_rdata <= mem[bus.mem_addr];
            log_addr[log_n[5:0]] <= bus.mem_addr;
            log_we[log_n[5:0]]   <= bus.mem_we;
            log_data[log_n[5:0]] <= bus.mem_we ? bus.mem_wdata : mem[bus.mem_addr];
            log_n <= log_n + 1;
            if (bus.mem_we)
                mem[bus.mem_addr] = bus.mem_wdata;
            wait_cnt <= 0;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    int         checks = 0;
    int         errors = 0;
    int         gap = 32;
    logic [7:0] tx [0:15];
    logic [7:0] rx [0:15];
    logic [7:0] miso;
    int         base;
    int         req_base;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One SPI byte: capture what the receiver would shift out, then deliver the received byte.
    task automatic applyStimulus(input logic [7:0] b, output logic [7:0] out_byte);
        out_byte = data_send;
        repeat (gap - 1) @(negedge clk);
        data_recv  = b;
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    task automatic sendFrame(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(tx[i], rx[i]);
    endtask

    task automatic frameStart();
        ssel_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frameEnd();
        ssel_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic waitBusIdle(input int limit);
        for (int i = 0; i < limit && (bus.mem_req || bus.mem_ack); i++)
            @(negedge clk);
        checkOutput("bus_idle_wait", {31'd0, bus.mem_req}, 32'd0);
    endtask

    task automatic checkLog(input string tag, input int idx, input logic [15:0] a,
                            input logic we, input logic [7:0] d);
        checkOutput({tag, "_addr"}, {16'd0, log_addr[idx]}, {16'd0, a});
        checkOutput({tag, "_we"},   {31'd0, log_we[idx]},   {31'd0, we});
        checkOutput({tag, "_data"}, {24'd0, log_data[idx]}, {24'd0, d});
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_data_send"}, {24'd0, data_send},     32'h00);
        checkOutput({tag, "_mem_req"},   {31'd0, bus.mem_req},   32'd0);
        checkOutput({tag, "_mem_we"},    {31'd0, bus.mem_we},    32'd0);
        checkOutput({tag, "_mem_addr"},  {16'd0, bus.mem_addr},  32'h0000);
        checkOutput({tag, "_mem_wdata"}, {24'd0, bus.mem_wdata}, 32'h00);
        checkOutput({tag, "_busy"},      {31'd0, busy},          32'd0);
        checkOutput({tag, "_err"},       {31'd0, err},           32'd0);
    endtask

    initial begin
        logic [7:0] exp_cnt;
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        mem[16'h0100] = 8'h55;
        mem[16'h0101] = 8'h66;
        mem[16'h0300] = 8'h31;
        mem[16'h0301] = 8'h32;
        mem[16'h0302] = 8'h33;
        mem[16'h0303] = 8'h34;
        mem[16'h0010] = 8'h00;
        mem[16'h2000] = 8'h00;

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write two bytes starting at 0x1234
        $display("[TB] write frame");
        base = log_n;
        tx[0] = 8'h01; tx[1] = 8'h12; tx[2] = 8'h34; tx[3] = 8'h02; tx[4] = 8'hAA; tx[5] = 8'hBB;
        frameStart();
        sendFrame(6);
        waitBusIdle(100);
        checkOutput("wr_count", log_n - base, 2);
        checkLog("wr0", base, 16'h1234, 1'b1, 8'hAA);
        checkLog("wr1", base + 1, 16'h1235, 1'b1, 8'hBB);
        checkOutput("wr_err", {31'd0, err}, 32'd0);
        checkOutput("wr_discard_busy", {31'd0, busy}, 32'd1);
        frameEnd();
        checkOutput("wr_idle_busy", {31'd0, busy}, 32'd0);

        // Read across the 0xFFFF -> 0x0000 wrap
        $display("[TB] read frame with address wrap");
        base = log_n;
        tx[0] = 8'h02; tx[1] = 8'hFF; tx[2] = 8'hFF; tx[3] = 8'h02;
        tx[4] = 8'h00; tx[5] = 8'h00; tx[6] = 8'h00;
        frameStart();
        sendFrame(7);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("rd_miso%0d", i), {24'd0, rx[i]}, 32'h00);
        checkOutput("rd_miso5", {24'd0, rx[5]}, 32'h11);
        checkOutput("rd_miso6", {24'd0, rx[6]}, 32'h22);
        checkOutput("rd_after_last", {24'd0, data_send}, 32'h00);
        waitBusIdle(100);
        checkOutput("rd_count", log_n - base, 2);
        checkLog("rd0", base, 16'hFFFF, 1'b0, 8'h11);
        checkLog("rd1", base + 1, 16'h0000, 1'b0, 8'h22);
        checkOutput("rd_err", {31'd0, err}, 32'd0);
        frameEnd();

        // Unknown command is swallowed without bus activity
        $display("[TB] unknown command");
        req_base = req_cycles;
        tx[0] = 8'h7E; tx[1] = 8'h01; tx[2] = 8'h02; tx[3] = 8'h03;
        frameStart();
        sendFrame(4);
        checkOutput("unk_miso1", {24'd0, rx[1]}, 32'h00);
        checkOutput("unk_miso3", {24'd0, rx[3]}, 32'h00);
        checkOutput("unk_send", {24'd0, data_send}, 32'h00);
        checkOutput("unk_busy", {31'd0, busy}, 32'd1);
        frameEnd();
        checkOutput("unk_no_req", req_cycles - req_base, 0);

`ifdef SPI_CMD_ERRCNT_EN
        exp_cnt = 8'h01;
`else
        exp_cnt = 8'h00;
`endif
        tx[0] = 8'h03; tx[1] = 8'h00;
        frameStart();
        sendFrame(2);
        frameEnd();
        checkOutput("errcnt_first", {24'd0, rx[1]}, {24'd0, exp_cnt});
        frameStart();
        sendFrame(2);
        frameEnd();
        checkOutput("errcnt_cleared", {24'd0, rx[1]}, 32'h00);

        // Slow bus: first returned byte underruns
        $display("[TB] slow bus read");
        lat = 200;
        gap = 64;
        tx[0] = 8'h02; tx[1] = 8'h01; tx[2] = 8'h00; tx[3] = 8'h02;
        tx[4] = 8'h00; tx[5] = 8'h00; tx[6] = 8'h00;
        frameStart();
        sendFrame(7);
        checkOutput("slow_first_byte", {24'd0, rx[5]}, 32'hEE);
        checkOutput("slow_err", {31'd0, err}, 32'd1);
        frameEnd();
        waitBusIdle(600);
        checkOutput("slow_err_sticky", {31'd0, err}, 32'd1);
        frameStart();
        checkOutput("slow_err_cleared", {31'd0, err}, 32'd0);
        frameEnd();
        lat = 50;
        gap = 32;

        // Deselect while a write is outstanding
        $display("[TB] deselect during write");
        base = log_n;
        tx[0] = 8'h01; tx[1] = 8'h20; tx[2] = 8'h00; tx[3] = 8'h03; tx[4] = 8'hA1;
        frameStart();
        sendFrame(5);
        checkOutput("abort_req_before", {31'd0, bus.mem_req}, 32'd1);
        ssel_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abort_req_held", {31'd0, bus.mem_req}, 32'd1);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        applyStimulus(8'hA2, miso);
        waitBusIdle(200);
        repeat (60) @(negedge clk);
        checkOutput("abort_one_txn", log_n - base, 1);
        checkOutput("abort_no_new_req", {31'd0, bus.mem_req}, 32'd0);
        checkLog("abort_wr", base, 16'h2000, 1'b1, 8'hA1);
        lat = 2;

        // Reset in the middle of a read payload, then a fresh write frame
        $display("[TB] reset mid-read");
        tx[0] = 8'h02; tx[1] = 8'h03; tx[2] = 8'h00; tx[3] = 8'h04;
        tx[4] = 8'h00; tx[5] = 8'h00;
        frameStart();
        sendFrame(6);
        checkOutput("mid_rd_send", {24'd0, data_send}, 32'h32);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkResetOutputs("midrst");
        frameEnd();
        waitBusIdle(100);
        base = log_n;
        tx[0] = 8'h01; tx[1] = 8'h00; tx[2] = 8'h10; tx[3] = 8'h01; tx[4] = 8'h5A;
        frameStart();
        sendFrame(5);
        waitBusIdle(100);
        frameEnd();
        checkOutput("post_rst_count", log_n - base, 1);
        checkLog("post_rst_wr", base, 16'h0010, 1'b1, 8'h5A);
        checkOutput("post_rst_mem", {24'd0, mem[16'h0010]}, 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop so a stuck run still terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
